data_cache: RTL and testbench

Direct-mapped, write-back, write-allocate data cache between the MEM stage and the 256-bit block memory port of the 5-stage MIPS core. On a hit it serves word reads and sub-word writes with no stall. On a miss it raises `STALL_OUT` to the Hazard unit and runs a victim write-back and refill over `MemBlockWrite_OUT`/`MemBlockRead_OUT`. The stalled pipeline holds the request and replays it once the line is installed.

---
 rtl/dcache_pkg.sv | 15 +
 rtl/dcache_byte_merge.sv | 24 ++
 rtl/data_cache.sv | 155 +++++++++++++++
 tb/tb_data_cache.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL
  } dcache_state_t;

  localparam int BLOCK_BYTES     = 32;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int OFFSET_BITS     = 5;
  localparam int BLOCK_BITS      = BLOCK_BYTES * 8;

endpackage

// File: rtl/dcache_byte_merge.sv
// Big-endian merge of 1..4 right-justified store bytes into a cached word.
module dcache_byte_merge (
  input  logic [31:0] oldWord,
  input  logic [31:0] wrData,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  output logic [31:0] newWord
);

  logic [1:0]  pad;
  logic [4:0]  lsh;
  logic [4:0]  rsh;
  logic [31:0] aligned;
  logic [31:0] mask;

  // pad = 4 - N bytes (size 0 means 4, so pad 0)
  assign pad     = 2'd0 - size;
  assign lsh     = {pad, 3'b000};
  assign rsh     = {offset, 3'b000};
  assign aligned = (wrData << lsh) >> rsh;
  assign mask    = (32'hFFFF_FFFF << lsh) >> rsh;
  assign newWord = (oldWord & ~mask) | (aligned & mask);

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back write-allocate data cache with block refill FSM.
// Optional hit/miss statistics enabled by defining DCACHE_STATS_EN.
module data_cache
  import dcache_pkg::*;
#(
  parameter int LINES       = 32,
  parameter int MEM_LATENCY = 4
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic [31:0]           Address_IN,
  input  logic                  MemRead_IN,
  input  logic                  MemWrite_IN,
  input  logic [31:0]           WriteData_IN,
  input  logic [1:0]            DataSize_IN,
  output logic [31:0]           ReadData_OUT,
  output logic                  STALL_OUT,
  output logic                  MemBlockRead_OUT,
  output logic                  MemBlockWrite_OUT,
  output logic [31:0]           BlockAddress_OUT,
  output logic [BLOCK_BITS-1:0] DataBlock_OUT,
  input  logic [BLOCK_BITS-1:0] DataBlock_IN,
  output logic [31:0]           HitCount_OUT,
  output logic [31:0]           MissCount_OUT
);

  localparam int IDX  = $clog2(LINES);
  localparam int TAGW = 32 - OFFSET_BITS - IDX;
  localparam int CW   = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_LATENCY - 1);

  dcache_state_t state, nextState;
  logic [CW-1:0] cnt, nextCnt;

  logic [LINES-1:0]      valid;
  logic [LINES-1:0]      dirty;
  logic [TAGW-1:0]       tags     [LINES];
  logic [BLOCK_BITS-1:0] lineData [LINES];

  logic [IDX-1:0]  idx;
  logic [TAGW-1:0] reqTag;
  logic [2:0]      word;
  logic            req;
  logic            hit;
  logic            lastCnt;
  logic [31:0]     mergedWord;

  assign idx     = Address_IN[OFFSET_BITS+IDX-1:OFFSET_BITS];
  assign reqTag  = Address_IN[31:OFFSET_BITS+IDX];
  assign word    = Address_IN[4:2];
  assign req     = MemRead_IN | MemWrite_IN;
  assign hit     = valid[idx] && (tags[idx] == reqTag);
  assign lastCnt = (cnt == LAST);

  assign ReadData_OUT = lineData[idx][{word, 5'b00000} +: 32];
  assign STALL_OUT    = !RESET && ((state != IDLE) || (req && !hit));

  dcache_byte_merge uMerge (
    .oldWord (ReadData_OUT),
    .wrData  (WriteData_IN),
    .size    (DataSize_IN),
    .offset  (Address_IN[1:0]),
    .newWord (mergedWord)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  always_comb begin
    nextState         = state;
    nextCnt           = cnt;
    MemBlockRead_OUT  = 1'b0;
    MemBlockWrite_OUT = 1'b0;
    BlockAddress_OUT  = '0;
    DataBlock_OUT     = '0;
    unique case (state)
      IDLE: begin
        if (req && !hit) begin
          nextCnt   = '0;
          nextState = (valid[idx] && dirty[idx]) ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        MemBlockWrite_OUT = 1'b1;
        BlockAddress_OUT  = {tags[idx], idx, {OFFSET_BITS{1'b0}}};
        DataBlock_OUT     = lineData[idx];
        nextCnt           = lastCnt ? '0 : cnt + 1'b1;
        if (lastCnt) nextState = REFILL;
      end
      REFILL: begin
        MemBlockRead_OUT = 1'b1;
        BlockAddress_OUT = {reqTag, idx, {OFFSET_BITS{1'b0}}};
        nextCnt          = lastCnt ? '0 : cnt + 1'b1;
        if (lastCnt) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      valid <= '0;
      dirty <= '0;
    end else if (state == REFILL && lastCnt) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (state == IDLE && hit && MemWrite_IN) begin
      dirty[idx] <= 1'b1;
    end
  end

  // Tags and data need no reset: valid gates every use
  always_ff @(posedge CLOCK) begin
    if (!RESET && state == REFILL && lastCnt) begin
      tags[idx]     <= reqTag;
      lineData[idx] <= DataBlock_IN;
    end else if (!RESET && state == IDLE && hit && MemWrite_IN) begin
      lineData[idx][{word, 5'b00000} +: 32] <= mergedWord;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hitCnt;
  logic [31:0] missCnt;
  logic        replay;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      hitCnt  <= '0;
      missCnt <= '0;
      replay  <= 1'b0;
    end else begin
      replay <= (state == REFILL) && lastCnt;
      if (state == IDLE && req) begin
        if (!hit) missCnt <= missCnt + 32'd1;
        else if (!replay) hitCnt <= hitCnt + 32'd1;
      end
    end
  end

  assign HitCount_OUT  = hitCnt;
  assign MissCount_OUT = missCnt;
`else
  assign HitCount_OUT  = '0;
  assign MissCount_OUT = '0;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Directed self-checking bench for data_cache (LINES=32, MEM_LATENCY=4).
module tb_data_cache;

  localparam int L = 4;

  logic         CLOCK = 1'b0;
  logic         RESET;
  logic [31:0]  Address_IN;
  logic         MemRead_IN;
  logic         MemWrite_IN;
  logic [31:0]  WriteData_IN;
  logic [1:0]   DataSize_IN;
  logic [31:0]  ReadData_OUT;
  logic         STALL_OUT;
  logic         MemBlockRead_OUT;
  logic         MemBlockWrite_OUT;
  logic [31:0]  BlockAddress_OUT;
  logic [255:0] DataBlock_OUT;
  logic [255:0] DataBlock_IN;
  logic [31:0]  HitCount_OUT;
  logic [31:0]  MissCount_OUT;

  int tests = 0;
  int fails = 0;

  data_cache #(.LINES(32), .MEM_LATENCY(L)) dut (
    .CLOCK             (CLOCK),
    .RESET             (RESET),
    .Address_IN        (Address_IN),
    .MemRead_IN        (MemRead_IN),
    .MemWrite_IN       (MemWrite_IN),
    .WriteData_IN      (WriteData_IN),
    .DataSize_IN       (DataSize_IN),
    .ReadData_OUT      (ReadData_OUT),
    .STALL_OUT         (STALL_OUT),
    .MemBlockRead_OUT  (MemBlockRead_OUT),
    .MemBlockWrite_OUT (MemBlockWrite_OUT),
    .BlockAddress_OUT  (BlockAddress_OUT),
    .DataBlock_OUT     (DataBlock_OUT),
    .DataBlock_IN      (DataBlock_IN),
    .HitCount_OUT      (HitCount_OUT),
    .MissCount_OUT     (MissCount_OUT)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [31:0] expRead;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    #2;
  endtask

  task automatic setReq(input logic [31:0] a, input logic rd,
                        input logic wr, input logic [31:0] d,
                        input logic [1:0] sz);
    Address_IN   = a;
    MemRead_IN   = rd;
    MemWrite_IN  = wr;
    WriteData_IN = d;
    DataSize_IN  = sz;
  endtask

  // Read miss from cycle 0 through the replay hit
  task automatic missRead(input logic [31:0] a, input bit dirtyV,
                          input logic [31:0] vAddr, input int vw,
                          input logic [31:0] vWord,
                          input logic [31:0] expData);
    int wb;
    wb = dirtyV ? L : 0;
    setReq(a, 1'b1, 1'b0, 32'h0, 2'd0);
    #1;
    chk("stall c0", {31'b0, STALL_OUT}, 32'd1);
    chk("blkrd c0", {31'b0, MemBlockRead_OUT}, 32'd0);
    chk("blkwr c0", {31'b0, MemBlockWrite_OUT}, 32'd0);
    for (int c = 1; c <= wb + L; c++) begin
      step();
      #1;
      chk("stall busy", {31'b0, STALL_OUT}, 32'd1);
      if (c <= wb) begin
        chk("blkwr wb", {31'b0, MemBlockWrite_OUT}, 32'd1);
        chk("blkrd wb", {31'b0, MemBlockRead_OUT}, 32'd0);
        chk("addr wb", BlockAddress_OUT, vAddr);
        chk("victim word", DataBlock_OUT[vw*32 +: 32], vWord);
      end else begin
        chk("blkrd rf", {31'b0, MemBlockRead_OUT}, 32'd1);
        chk("blkwr rf", {31'b0, MemBlockWrite_OUT}, 32'd0);
        chk("addr rf", BlockAddress_OUT, {a[31:5], 5'b0});
      end
    end
    step();
    #1;
    chk("stall end", {31'b0, STALL_OUT}, 32'd0);
    chk("replay data", ReadData_OUT, expData);
    chk("blkrd end", {31'b0, MemBlockRead_OUT}, 32'd0);
    chk("addr end", BlockAddress_OUT, 32'd0);
  endtask

  initial begin
    for (int w = 0; w < 8; w++)
      DataBlock_IN[w*32 +: 32] = (w == 0) ? 32'hDEADBEEF
                                          : 32'h11111111 * w;

    vecs[0]  = '{32'h10000C44, 1, 0, 32'h0,        2'd0, 32'h11111111};
    vecs[1]  = '{32'h10000C48, 0, 1, 32'h0000BBCC, 2'd2, 32'h22222222};
    vecs[2]  = '{32'h10000C48, 1, 0, 32'h0,        2'd0, 32'hBBCC2222};
    vecs[3]  = '{32'h10000C4E, 0, 1, 32'h00001234, 2'd2, 32'h33333333};
    vecs[4]  = '{32'h10000C4C, 1, 0, 32'h0,        2'd0, 32'h33331234};
    vecs[5]  = '{32'h10000C50, 0, 1, 32'hCAFEF00D, 2'd0, 32'h44444444};
    vecs[6]  = '{32'h10000C50, 1, 0, 32'h0,        2'd0, 32'hCAFEF00D};
    vecs[7]  = '{32'h10000C57, 0, 1, 32'hFFFFFF77, 2'd1, 32'h55555555};
    vecs[8]  = '{32'h10000C54, 1, 0, 32'h0,        2'd0, 32'h55555577};
    vecs[9]  = '{32'h10000C59, 0, 1, 32'h00ABCDEF, 2'd3, 32'h66666666};
    vecs[10] = '{32'h10000C58, 1, 0, 32'h0,        2'd0, 32'h66ABCDEF};
    vecs[11] = '{32'h10000C5C, 1, 1, 32'h00000099, 2'd1, 32'h77777777};
    vecs[12] = '{32'h10000C5C, 1, 0, 32'h0,        2'd0, 32'h99777777};
    vecs[13] = '{32'h10000C42, 1, 0, 32'h0,        2'd0, 32'hDEADBEEF};

    RESET = 1'b1;
    setReq(32'h10000040, 1'b1, 1'b0, 32'h0, 2'd0);
    step();
    step();
    #1;
    chk("rst stall", {31'b0, STALL_OUT}, 32'd0);
    chk("rst blkrd", {31'b0, MemBlockRead_OUT}, 32'd0);
    chk("rst blkwr", {31'b0, MemBlockWrite_OUT}, 32'd0);
    chk("rst addr", BlockAddress_OUT, 32'd0);
    chk("rst hits", HitCount_OUT, 32'd0);
    chk("rst miss", MissCount_OUT, 32'd0);

    step();
    RESET = 1'b0;
    MemRead_IN = 1'b0;
    #1;
    chk("idle stall", {31'b0, STALL_OUT}, 32'd0);

    step();
    missRead(32'h10000040, 0, 32'h0, 0, 32'h0, 32'hDEADBEEF);

    step();
    setReq(32'h10000041, 1'b0, 1'b1, 32'h000000AA, 2'd1);
    #1;
    chk("bytewr stall", {31'b0, STALL_OUT}, 32'd0);
    step();
    setReq(32'h10000040, 1'b1, 1'b0, 32'h0, 2'd0);
    #1;
    chk("bytewr stall2", {31'b0, STALL_OUT}, 32'd0);
    chk("bytewr data", ReadData_OUT, 32'hDEAABEEF);
    step();
    MemRead_IN = 1'b0;
    #1;
`ifdef DCACHE_STATS_EN
    chk("miss count", MissCount_OUT, 32'd1);
    chk("hit count", HitCount_OUT, 32'd2);
`else
    chk("miss count", MissCount_OUT, 32'd0);
    chk("hit count", HitCount_OUT, 32'd0);
`endif

    step();
    missRead(32'h10000440, 1, 32'h10000040, 0, 32'hDEAABEEF,
             32'hDEADBEEF);
    step();
    missRead(32'h10000840, 0, 32'h0, 0, 32'h0, 32'hDEADBEEF);

    step();
    setReq(32'h10000C40, 1'b1, 1'b0, 32'h0, 2'd0);
    step();
    step();
    RESET = 1'b1;
    #1;
    chk("stall in rst", {31'b0, STALL_OUT}, 32'd0);
    step();
    RESET = 1'b0;
    #1;
    chk("abort blkrd", {31'b0, MemBlockRead_OUT}, 32'd0);
    missRead(32'h10000C40, 0, 32'h0, 0, 32'h0, 32'hDEADBEEF);

    foreach (vecs[i]) begin
      step();
      setReq(vecs[i].addr, vecs[i].rd, vecs[i].wr,
             vecs[i].wdata, vecs[i].size);
      #1;
      chk($sformatf("vec%0d stall", i), {31'b0, STALL_OUT}, 32'd0);
      chk($sformatf("vec%0d data", i), ReadData_OUT, vecs[i].expRead);
    end

    step();
    missRead(32'h10000040, 1, 32'h10000C40, 4, 32'hCAFEF00D,
             32'hDEADBEEF);

    step();
    MemRead_IN = 1'b0;
    MemWrite_IN = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
